muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit; companion to the single-cycle integer ALU in the EX stage.
- Accepts one operation per valid/ready handshake and computes it over multiple cycles with a shift-add multiplier and a restoring divider.
- Holds the result until the pipeline consumes it.
- Parametrised in data width and supports pipeline flush.

Parameters:
- XLEN, 32, operand/result width (power of two, >= 8).
- CNT_W, $clog2(XLEN)+1, iteration counter width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- valid_muldiv_i  input  1  request valid.
- ready_muldiv_o  output  1  unit can accept a request (state IDLE).
- op_muldiv_i  input  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- opr_a_muldiv_i  input  XLEN  rs1 operand (dividend/multiplicand).
- opr_b_muldiv_i  input  XLEN  rs2 operand (divisor/multiplier).
- kill_muldiv_i  input  1  flush; abandons any operation in flight.
- valid_muldiv_o  output  1  result valid (state DONE).
- ready_muldiv_i  input  1  consumer accepts the result.
- res_muldiv_o  output  XLEN  result; stable while valid_muldiv_o=1.
- busy_muldiv_o  output  1  state != IDLE (used by the hazard unit for stall).

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; counter, accumulators and res_muldiv_o cleared to 0.
  - ready_muldiv_o=1, valid_muldiv_o=0, busy_muldiv_o=0.
- Request acceptance: a request is accepted in cycle 0 when valid_muldiv_i & ready_muldiv_o. Operands and op are latched; the inputs are don't-care afterwards.
- States:
  - IDLE -> CALC on accept.
  - IDLE -> DONE directly on a special case.
  - CALC: one iteration per cycle for XLEN cycles; counter counts XLEN-1 down to 0. At 0 -> FIXUP.
  - FIXUP: one cycle. Applies sign correction, selects the high or low half (or the quotient/remainder), and registers res. Then -> DONE.
  - DONE: valid_muldiv_o=1. Leaves to IDLE when ready_muldiv_i=1. No back-to-back accept in the same cycle; the next accept is possible the cycle after.
- Normal latency: valid_muldiv_o rises in cycle XLEN+2 after the accept cycle (cycle 34 for XLEN=32).
- Multiply:
  - Operands are converted to magnitudes according to signedness: MULH both signed; MULHSU a signed, b unsigned; MULHU and MUL unsigned.
  - A 2*XLEN product is accumulated by shift-add.
  - FIXUP negates the product if the operand signs differ.
  - MUL returns low XLEN bits; the MULH* ops return high XLEN bits.
- Divide:
  - Restoring, on magnitudes for DIV/REM.
  - The quotient is negated if the signs differ.
  - The remainder takes the sign of the dividend.
- Special cases (IDLE -> DONE, valid_muldiv_o in cycle 1):
  - Divisor 0: DIV/DIVU return all-ones; REM/REMU return the dividend.
  - Signed overflow (a = most-negative, b = -1): DIV returns most-negative; REM returns 0.
- Kill:
  - kill_muldiv_i=1 in any state forces IDLE at the next edge and suppresses valid_muldiv_o; res is unchanged.
  - kill has priority over accept and over ready_muldiv_i in the same cycle.
  - A request presented with kill is not accepted.
- Reset mid-operation: returns immediately to the reset values; no partial result is emitted.
- Arithmetic: all internal adders are XLEN+1 bits wide; no X propagates to res_muldiv_o for any op encoding.

Decomposition:
- Shared package/defines file (alongside the ALU defines):
  - MULDIV op codes MUL_OP..REMU_OP.
  - State encoding IDLE/CALC/FIXUP/DONE.
- One natural sub-module, muldiv_datapath: the iteration datapath (shift-add step and restoring subtract step, plus sign fixup).
- Control FSM and handshake stay in muldiv_unit.

Test Plan:
- MUL a=7, b=6 -> res=42, valid_muldiv_o exactly at cycle 34 after accept; ready_muldiv_o=0 cycles 1..34.
- MULH a=0xFFFFFFFF (-1), b=0xFFFFFFFF -> res=0x00000000; MULHU same operands -> 0xFFFFFFFE; MULHSU a=-1, b=2 -> 0xFFFFFFFF.
- DIV a=-7, b=2 -> res=0xFFFFFFFD (-3); REM a=-7, b=2 -> 0xFFFFFFFF (-1); DIVU a=7, b=2 -> 3.
- DIV a=5, b=0 -> 0xFFFFFFFF at cycle 1; REMU a=5, b=0 -> 5; DIV a=0x80000000, b=-1 -> 0x80000000; REM same operands -> 0.
- Back-pressure: hold ready_muldiv_i=0 for 5 cycles in DONE -> valid and res stable; release -> IDLE the next cycle; kill asserted at CALC cycle 10 -> IDLE next cycle, no valid_muldiv_o.
- reset_n pulsed low mid-CALC (asynchronous, between edges) -> outputs return to reset values immediately; XLEN=64 instance: MUL 2^32 * 2^32 -> high word of MULHU = 1, latency 66.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
// Holds the funct3 operation codes, the control-state encoding and small
// decode helpers used by both the control FSM and the datapath.
package muldiv_pkg;

    localparam logic [2:0] MUL_OP    = 3'd0;
    localparam logic [2:0] MULH_OP   = 3'd1;
    localparam logic [2:0] MULHSU_OP = 3'd2;
    localparam logic [2:0] MULHU_OP  = 3'd3;
    localparam logic [2:0] DIV_OP    = 3'd4;
    localparam logic [2:0] DIVU_OP   = 3'd5;
    localparam logic [2:0] REM_OP    = 3'd6;
    localparam logic [2:0] REMU_OP   = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Divide family is the upper half of the funct3 space.
    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // rs1 is treated as signed by MULH, MULHSU, DIV and REM.
    function automatic logic a_is_signed(input logic [2:0] op);
        return (op == MULH_OP) || (op == MULHSU_OP) || (op == DIV_OP) || (op == REM_OP);
    endfunction

    // rs2 is treated as signed by MULH, DIV and REM.
    function automatic logic b_is_signed(input logic [2:0] op);
        return (op == MULH_OP) || (op == DIV_OP) || (op == REM_OP);
    endfunction

    // Ops whose result comes from the low register (product low word or quotient).
    function automatic logic takes_low(input logic [2:0] op);
        return (op == MUL_OP) || (op == DIV_OP) || (op == DIVU_OP);
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Iteration datapath for muldiv_unit.
// A {hi, lo} register pair is shared by both algorithms:
//   multiply: lo starts as the multiplier magnitude, hi accumulates; each step
//             conditionally adds the multiplicand and shifts {carry,hi,lo} right.
//   divide:   lo starts as the dividend magnitude and fills with quotient bits,
//             hi holds the partial remainder (restoring algorithm).
// Ports:
//   clk, reset_n          clock, async active-low reset
//   load                  latch op/operands (magnitudes) and clear hi
//   step                  perform one iteration
//   op_in, a_in, b_in     request fields (only sampled on load / for special)
//   special, special_res  divide-by-zero / signed-overflow detection on inputs
//   result                sign-corrected final result, valid after XLEN steps
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load,
    input  logic            step,
    input  logic [2:0]      op_in,
    input  logic [XLEN-1:0] a_in,
    input  logic [XLEN-1:0] b_in,
    output logic            special,
    output logic [XLEN-1:0] special_res,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] ONE     = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [XLEN-1:0] hi, lo, opd;
    logic [2:0]      op_q;
    logic            neg;

    logic            a_neg, b_neg, div_zero, overflow, ge, hi_cin;
    logic [XLEN-1:0] a_mag, b_mag, lo_neg, hi_neg;
    logic [XLEN:0]   sum, shifted, diff, lo_inc;

    always_comb begin
        a_neg = a_is_signed(op_in) & a_in[XLEN-1];
        b_neg = b_is_signed(op_in) & b_in[XLEN-1];
        a_mag = a_neg ? (~a_in + ONE) : a_in;
        b_mag = b_neg ? (~b_in + ONE) : b_in;

        // Multiply step: hi + (multiplier bit ? multiplicand : 0), carry kept.
        sum = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);

        // Restoring divide step: trial subtract from the shifted remainder.
        // The top bit of diff is the borrow: clear means the subtraction fits.
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, opd};
        ge      = ~diff[XLEN];

        div_zero = is_div(op_in) & (b_in == '0);
        overflow = is_div(op_in) & b_is_signed(op_in) & (a_in == MOST_NEG) & (b_in == '1);
        special  = div_zero | overflow;
        special_res = '0;
        if (div_zero) begin
            special_res = takes_low(op_in) ? '1 : a_in;
        end else if (overflow) begin
            special_res = (op_in == DIV_OP) ? MOST_NEG : '0;
        end

        // Negation: for a product the carry out of the low word ripples into
        // the high word; a remainder in hi is negated on its own.
        lo_inc = {1'b0, ~lo} + {{XLEN{1'b0}}, 1'b1};
        lo_neg = lo_inc[XLEN-1:0];
        hi_cin = is_div(op_q) | lo_inc[XLEN];
        hi_neg = ~hi + {{(XLEN-1){1'b0}}, hi_cin};
        result = takes_low(op_q) ? (neg ? lo_neg : lo) : (neg ? hi_neg : hi);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi   <= '0;
            lo   <= '0;
            opd  <= '0;
            op_q <= '0;
            neg  <= 1'b0;
        end else if (load) begin
            op_q <= op_in;
            hi   <= '0;
            // REM takes the dividend sign; everything else the sign product.
            neg  <= a_neg ^ (b_neg & (op_in != REM_OP));
            if (is_div(op_in)) begin
                lo  <= a_mag;
                opd <= b_mag;
            end else begin
                lo  <= b_mag;
                opd <= a_mag;
            end
        end else if (step) begin
            if (is_div(op_q)) begin
                hi <= ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
                lo <= {lo[XLEN-2:0], ge};
            end else begin
                hi <= sum[XLEN:1];
                lo <= {sum[0], lo[XLEN-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (EX-stage companion to the ALU).
// One request per valid/ready handshake; XLEN iterations, one fixup cycle,
// then the result is held until consumed. Divide-by-zero and signed overflow
// complete immediately. kill abandons any operation without touching res.
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   valid_muldiv_i / ready_muldiv_o   request handshake (ready in IDLE)
//   op_muldiv_i                       funct3 op code
//   opr_a_muldiv_i / opr_b_muldiv_i   rs1 / rs2 operands
//   kill_muldiv_i                     pipeline flush
//   valid_muldiv_o / ready_muldiv_i   result handshake (valid in DONE)
//   res_muldiv_o                      registered result
//   busy_muldiv_o                     unit not idle (stall source)
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            valid_muldiv_i,
    output logic            ready_muldiv_o,
    input  logic [2:0]      op_muldiv_i,
    input  logic [XLEN-1:0] opr_a_muldiv_i,
    input  logic [XLEN-1:0] opr_b_muldiv_i,
    input  logic            kill_muldiv_i,
    output logic            valid_muldiv_o,
    input  logic            ready_muldiv_i,
    output logic [XLEN-1:0] res_muldiv_o,
    output logic            busy_muldiv_o
);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [XLEN-1:0]  res;
    logic             load, step, load_fix, load_spec;
    logic             special;
    logic [XLEN-1:0]  special_res, result;

    muldiv_datapath #(.XLEN(XLEN)) u_datapath (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (load),
        .step        (step),
        .op_in       (op_muldiv_i),
        .a_in        (opr_a_muldiv_i),
        .b_in        (opr_b_muldiv_i),
        .special     (special),
        .special_res (special_res),
        .result      (result)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            res   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (load_fix) begin
                res <= result;
            end else if (load_spec) begin
                res <= special_res;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load       = 1'b0;
        step       = 1'b0;
        load_fix   = 1'b0;
        load_spec  = 1'b0;
        unique case (state)
            IDLE: begin
                if (valid_muldiv_i) begin
                    if (special) begin
                        state_next = DONE;
                        load_spec  = 1'b1;
                    end else begin
                        state_next = CALC;
                        cnt_next   = CNT_W'(XLEN - 1);
                        load       = 1'b1;
                    end
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt == '0) begin
                    state_next = FIXUP;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            FIXUP: begin
                load_fix   = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                if (ready_muldiv_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Flush wins over accept, iteration and consume; res is left alone.
        if (kill_muldiv_i) begin
            state_next = IDLE;
            load       = 1'b0;
            step       = 1'b0;
            load_fix   = 1'b0;
            load_spec  = 1'b0;
        end
    end

    assign ready_muldiv_o = (state == IDLE);
    assign valid_muldiv_o = (state == DONE);
    assign busy_muldiv_o  = (state != IDLE);
    assign res_muldiv_o   = res;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, valid_in, kill, ready_in;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        ready_out, valid_out, busy;
    logic [31:0] res;

    logic        valid64, kill64, ready_in64;
    logic [2:0]  op64;
    logic [63:0] a64, b64;
    logic        ready_out64, valid_out64, busy64;
    logic [63:0] res64;

    int checks = 0;
    int failures = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .valid_muldiv_i(valid_in), .ready_muldiv_o(ready_out),
        .op_muldiv_i(op), .opr_a_muldiv_i(a), .opr_b_muldiv_i(b),
        .kill_muldiv_i(kill), .valid_muldiv_o(valid_out),
        .ready_muldiv_i(ready_in), .res_muldiv_o(res), .busy_muldiv_o(busy)
    );

    muldiv_unit #(.XLEN(64)) dut64 (
        .clk(clk), .reset_n(reset_n),
        .valid_muldiv_i(valid64), .ready_muldiv_o(ready_out64),
        .op_muldiv_i(op64), .opr_a_muldiv_i(a64), .opr_b_muldiv_i(b64),
        .kill_muldiv_i(kill64), .valid_muldiv_o(valid_out64),
        .ready_muldiv_i(ready_in64), .res_muldiv_o(res64), .busy_muldiv_o(busy64)
    );

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expv;
        logic [7:0]  lat;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: RV32M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy;
        logic [63:0] ux, uy, p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        p  = '0;
        case (o)
            3'd0: p = ux * uy;
            3'd1: begin p = sx * sy; p = p >> 32; end
            3'd2: begin p = sx * longint'(uy); p = p >> 32; end
            3'd3: begin p = ux * uy; p = p >> 32; end
            3'd4: if (y == 0) p = '1;
                  else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) p = {32'd0, x};
                  else p = sx / sy;
            3'd5: if (y == 0) p = '1; else p = ux / uy;
            3'd6: if (y == 0) p = ux;
                  else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) p = '0;
                  else p = sx % sy;
            default: if (y == 0) p = ux; else p = ux % uy;
        endcase
        return p[31:0];
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o[2] && (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
            return 1;
        return 34;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one request, wait (bounded) for valid; reports result and latency.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output int lat, output bit rdy_low);
        @(negedge clk);
        check("ready_before_accept", ready_out, 1);
        valid_in = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        valid_in = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        lat = 1;
        rdy_low = 1'b1;
        while (valid_out !== 1'b1 && lat < 200) begin
            if (ready_out !== 1'b0 || busy !== 1'b1) rdy_low = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (ready_out !== 1'b0) rdy_low = 1'b0;
        r = res;
        $display("op=%0d a=%h b=%h res=%h lat=%0d", o, x, y, r, lat);
    endtask

    initial begin
        logic [31:0] r, expv, held;
        int          lat;
        bit          rdy_low, ok, seen;

        reset_n = 1'b0; valid_in = 1'b0; kill = 1'b0; ready_in = 1'b1;
        op = '0; a = '0; b = '0;
        valid64 = 1'b0; kill64 = 1'b0; ready_in64 = 1'b1; op64 = '0; a64 = '0; b64 = '0;

        vecs[0]  = '{MUL_OP,    32'd7,          32'd6,          32'd42,         8'd34};
        vecs[1]  = '{MULH_OP,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000,  8'd34};
        vecs[2]  = '{MULHU_OP,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  8'd34};
        vecs[3]  = '{MULHSU_OP, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  8'd34};
        vecs[4]  = '{DIV_OP,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  8'd34};
        vecs[5]  = '{REM_OP,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  8'd34};
        vecs[6]  = '{DIVU_OP,   32'd7,          32'd2,          32'd3,          8'd34};
        vecs[7]  = '{DIV_OP,    32'd5,          32'd0,          32'hFFFF_FFFF,  8'd1};
        vecs[8]  = '{REMU_OP,   32'd5,          32'd0,          32'd5,          8'd1};
        vecs[9]  = '{DIV_OP,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  8'd1};
        vecs[10] = '{REM_OP,    32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000,  8'd1};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset_flags", {ready_out, valid_out, busy}, 3'b100);
        check("reset_res", res, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed vectors
        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, r, lat, rdy_low);
            check($sformatf("dir%0d_res", i), r, vecs[i].expv);
            check($sformatf("dir%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("dir%0d_ready_low", i), rdy_low, 1);
            @(posedge clk); #1;
            check($sformatf("dir%0d_idle_after", i), {ready_out, valid_out, busy}, 3'b100);
        end

        // Back-pressure: result held stable while the consumer stalls
        ready_in = 1'b0;
        expv = ref_model(MULHU_OP, 32'h1234_5678, 32'h9ABC_DEF0);
        do_op(MULHU_OP, 32'h1234_5678, 32'h9ABC_DEF0, r, lat, rdy_low);
        check("bp_res", r, expv);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (valid_out !== 1'b1 || res !== expv) ok = 1'b0;
        end
        check("bp_stable", ok, 1);
        @(negedge clk);
        ready_in = 1'b1;
        @(posedge clk); #1;
        check("bp_release_idle", {ready_out, valid_out, busy}, 3'b100);
        held = expv;

        // Kill at CALC cycle 10
        @(negedge clk);
        valid_in = 1'b1; op = MUL_OP; a = 32'd3; b = 32'd5;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("kill_in_calc_busy", busy, 1);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_idle", {ready_out, valid_out, busy}, 3'b100);
        check("kill_res_kept", res, held);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (valid_out !== 1'b0) seen = 1'b1;
        end
        check("kill_no_valid", seen, 0);

        // Request together with kill is not accepted
        @(negedge clk);
        kill = 1'b1; valid_in = 1'b1; op = DIV_OP; a = 32'd5; b = 32'd0;
        @(posedge clk); #1;
        kill = 1'b0; valid_in = 1'b0;
        check("kill_blocks_accept", {ready_out, valid_out, busy}, 3'b100);
        check("kill_blocks_res", res, held);

        // Kill in DONE beats ready and keeps res
        ready_in = 1'b0;
        expv = ref_model(DIVU_OP, 32'd1000, 32'd7);
        do_op(DIVU_OP, 32'd1000, 32'd7, r, lat, rdy_low);
        check("kdone_res", r, expv);
        @(negedge clk);
        kill = 1'b1; ready_in = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kdone_idle", {ready_out, valid_out, busy}, 3'b100);
        check("kdone_res_kept", res, expv);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        valid_in = 1'b1; op = MUL_OP; a = 32'd1234; b = 32'd5678;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_flags", {ready_out, valid_out, busy}, 3'b100);
        check("areset_res", res, 0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (valid_out !== 1'b0) seen = 1'b1;
        end
        check("areset_no_valid", seen, 0);

        // Randomized operations against the reference model
        for (int i = 0; i < 30; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = pick_operand();
            rb = pick_operand();
            do_op(ro, ra, rb, r, lat, rdy_low);
            check($sformatf("rnd%0d_res", i), r, ref_model(ro, ra, rb));
            check($sformatf("rnd%0d_lat", i), lat, ref_latency(ro, ra, rb));
            @(posedge clk); #1;
            check($sformatf("rnd%0d_idle_after", i), {ready_out, valid_out, busy}, 3'b100);
        end

        // XLEN=64: MULHU 2^32 * 2^32 = 2^64 -> high word 1, latency 66
        @(negedge clk);
        valid64 = 1'b1; op64 = MULHU_OP; a64 = 64'h1_0000_0000; b64 = 64'h1_0000_0000;
        @(posedge clk); #1;
        valid64 = 1'b0;
        lat = 1;
        while (valid_out64 !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("xlen64 op=%0d res=%h lat=%0d", MULHU_OP, res64, lat);
        check("x64_res", res64, 64'd1);
        check("x64_lat", lat, 66);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
